// File: rtl/hamming74_rx_decoder.sv
// hamming74_rx_decoder
//   Takes each Hamming(7,4) codeword from the UART receiver on the rising edge of its
//   level-type valid flag. The codeword is registered, then decoded one ena-cycle later:
//   the syndrome is computed, any single-bit error is corrected, and {corrected, nibble}
//   is pushed into a small output FIFO. The FIFO drains through a valid/ready handshake.
//   A saturating counter tracks corrected words, and a sticky flag records any word that
//   was dropped because the FIFO was full.
//
// Ports
//   clk            in   system clock
//   rst_n          in   asynchronous active-low reset
//   ena            in   clock enable; no state changes (including pops) while low
//   code_in        in   [6:0] codeword, bit0 = Hamming position 1
//   code_valid     in   level valid from the receiver, held until the next frame
//   stats_clr      in   synchronous clear of corr_count and overflow (qualified by ena)
//   data_out       out  [3:0] FIFO head nibble {d4,d3,d2,d1}
//   data_corrected out  FIFO head was corrected
//   out_valid      out  FIFO non-empty
//   out_ready      in   downstream accepts the head entry
//   corr_count     out  [CNT_W-1:0] number of corrected words pushed, saturating
//   overflow       out  sticky: a decoded word was dropped on a full FIFO
module hamming74_rx_decoder #(
    parameter int unsigned FIFO_DEPTH = 4,
    parameter int unsigned CNT_W      = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             ena,
    input  logic [6:0]       code_in,
    input  logic             code_valid,
    input  logic             stats_clr,
    output logic [3:0]       data_out,
    output logic             data_corrected,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [CNT_W-1:0] corr_count,
    output logic             overflow
);

    localparam int unsigned PtrW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int unsigned CntW = PtrW + 1;
    localparam logic [CntW-1:0] FullCount = CntW'(FIFO_DEPTH);

    // Edge detect and capture stage
    logic       cv_q;
    logic [6:0] cw_q;
    logic       stg_v_q;
    logic       capture;

    // Decode
    logic [2:0] syn;
    logic [6:0] cw_fix;
    logic [3:0] nibble;
    logic       corrected;

    // FIFO
    logic [4:0]      mem_q [FIFO_DEPTH];
    logic [PtrW-1:0] wr_ptr_q;
    logic [PtrW-1:0] rd_ptr_q;
    logic [CntW-1:0] count_q;
    logic            push;
    logic            pop;
    logic            full;
    logic            push_ok;
    logic            drop;

    // Statistics
    logic [CNT_W-1:0] corr_count_q;
    logic             overflow_q;

    assign capture = ena & code_valid & ~cv_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cv_q    <= 1'b0;
            cw_q    <= 7'd0;
            stg_v_q <= 1'b0;
        end else if (ena) begin
            cv_q    <= code_valid;
            stg_v_q <= capture;
            if (capture) begin
                cw_q <= code_in;
            end
        end
    end

    // Syndrome value s names the erroneous Hamming position; position p lives in bit p-1.
    always_comb begin
        syn[0] = ^{cw_q[0], cw_q[2], cw_q[4], cw_q[6]};
        syn[1] = ^{cw_q[1], cw_q[2], cw_q[5], cw_q[6]};
        syn[2] = ^{cw_q[3], cw_q[4], cw_q[5], cw_q[6]};
        for (int i = 0; i < 7; i++) begin
            cw_fix[i] = cw_q[i] ^ (syn == 3'(i + 1));
        end
        nibble    = {cw_fix[6], cw_fix[5], cw_fix[4], cw_fix[2]};
        corrected = (syn != 3'd0);
    end

    always_comb begin
        full    = (count_q == FullCount);
        pop     = ena & (count_q != '0) & out_ready;
        push    = ena & stg_v_q;
        // A full FIFO still accepts a push when the head leaves in the same cycle.
        push_ok = push & (~full | pop);
        drop    = push & full & ~pop;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < int'(FIFO_DEPTH); i++) begin
                mem_q[i] <= 5'd0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push_ok) begin
                mem_q[wr_ptr_q] <= {corrected, nibble};
                wr_ptr_q        <= wr_ptr_q + 1'b1;
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
            unique case ({push_ok, pop})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            corr_count_q <= '0;
            overflow_q   <= 1'b0;
        end else if (ena) begin
            if (stats_clr) begin
                corr_count_q <= '0;
                overflow_q   <= 1'b0;
            end else begin
                if (push_ok && corrected && (corr_count_q != '1)) begin
                    corr_count_q <= corr_count_q + 1'b1;
                end
                if (drop) begin
                    overflow_q <= 1'b1;
                end
            end
        end
    end

    assign data_out       = mem_q[rd_ptr_q][3:0];
    assign data_corrected = mem_q[rd_ptr_q][4];
    assign out_valid      = (count_q != '0);
    assign corr_count     = corr_count_q;
    assign overflow       = overflow_q;

endmodule

// File: tb/tb_hamming74_rx_decoder.sv
module tb_hamming74_rx_decoder;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       ena = 1'b1;
    logic [6:0] code_in = 7'd0;
    logic       code_valid = 1'b0;
    logic       stats_clr = 1'b0;
    logic [3:0] data_out;
    logic       data_corrected;
    logic       out_valid;
    logic       out_ready = 1'b0;
    logic [7:0] corr_count;
    logic       overflow;

    int checks = 0;
    int errors = 0;
    int exp_cc = 0;

    typedef struct {
        logic [6:0] code;
        logic [3:0] nib;
        logic       corr;
    } vec_t;

    vec_t vecs[12];
    logic [3:0] exp_q[$];

    hamming74_rx_decoder #(.FIFO_DEPTH(4), .CNT_W(8)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .ena            (ena),
        .code_in        (code_in),
        .code_valid     (code_valid),
        .stats_clr      (stats_clr),
        .data_out       (data_out),
        .data_corrected (data_corrected),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .corr_count     (corr_count),
        .overflow       (overflow)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // All tasks start and end just after a negedge; the DUT is sampled there.
    task automatic send(input logic [6:0] c);
        code_in    = c;
        code_valid = 1'b1;
        @(negedge clk);            // capture edge
        code_valid = 1'b0;
        @(negedge clk);            // push edge
    endtask

    task automatic pop_one();
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
    endtask

    initial begin
        vecs[0]  = '{7'h55, 4'hB, 1'b0};
        vecs[1]  = '{7'h54, 4'hB, 1'b1};
        vecs[2]  = '{7'h57, 4'hB, 1'b1};
        vecs[3]  = '{7'h51, 4'hB, 1'b1};
        vecs[4]  = '{7'h5D, 4'hB, 1'b1};
        vecs[5]  = '{7'h45, 4'hB, 1'b1};
        vecs[6]  = '{7'h75, 4'hB, 1'b1};
        vecs[7]  = '{7'h15, 4'hB, 1'b1};
        vecs[8]  = '{7'h00, 4'h0, 1'b0};
        vecs[9]  = '{7'h7F, 4'hF, 1'b0};
        vecs[10] = '{7'h7E, 4'hF, 1'b1};
        vecs[11] = '{7'h01, 4'h0, 1'b1};

        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        check("reset out_valid", 32'(out_valid), 0);
        check("reset data_out", 32'(data_out), 0);
        check("reset corr_count", 32'(corr_count), 0);
        check("reset overflow", 32'(overflow), 0);

        // Latency: first word
        code_in    = 7'h55;
        code_valid = 1'b1;
        @(negedge clk);
        code_valid = 1'b0;
        check("latency not early", 32'(out_valid), 0);
        @(negedge clk);
        check("latency valid", 32'(out_valid), 1);
        check("latency data", 32'(data_out), 32'hB);
        pop_one();

        // Table-driven decode vectors
        for (int i = 0; i < 12; i++) begin
            send(vecs[i].code);
            if (vecs[i].corr) exp_cc++;
            check($sformatf("vec%0d valid", i), 32'(out_valid), 1);
            check($sformatf("vec%0d data", i), 32'(data_out), 32'(vecs[i].nib));
            check($sformatf("vec%0d corr", i), 32'(data_corrected), 32'(vecs[i].corr));
            check($sformatf("vec%0d count", i), 32'(corr_count), 32'(exp_cc));
            pop_one();
            check($sformatf("vec%0d empty", i), 32'(out_valid), 0);
        end

        // Held level captures once; drop and raise captures again
        code_in    = 7'h7F;
        code_valid = 1'b1;
        repeat (20) @(negedge clk);
        check("held valid", 32'(out_valid), 1);
        check("held data", 32'(data_out), 32'hF);
        pop_one();
        repeat (3) @(negedge clk);
        check("held single push", 32'(out_valid), 0);
        code_valid = 1'b0;
        @(negedge clk);
        code_valid = 1'b1;
        repeat (2) @(negedge clk);
        check("reraise valid", 32'(out_valid), 1);
        check("reraise data", 32'(data_out), 32'hF);
        code_valid = 1'b0;
        pop_one();
        check("reraise empty", 32'(out_valid), 0);

        // Overflow: five words into a depth-4 FIFO
        send(7'h00); send(7'h7F); send(7'h55); send(7'h00);
        check("no overflow yet", 32'(overflow), 0);
        send(7'h7F);
        check("overflow set", 32'(overflow), 1);
        exp_q = '{4'h0, 4'hF, 4'hB, 4'h0};
        foreach (exp_q[i]) begin
            check($sformatf("drain%0d valid", i), 32'(out_valid), 1);
            check($sformatf("drain%0d data", i), 32'(data_out), 32'(exp_q[i]));
            pop_one();
        end
        check("drain empty", 32'(out_valid), 0);
        check("overflow sticky", 32'(overflow), 1);
        stats_clr = 1'b1;
        @(negedge clk);
        stats_clr = 1'b0;
        exp_cc = 0;
        check("clr overflow", 32'(overflow), 0);
        check("clr count", 32'(corr_count), 0);

        // Full FIFO with a simultaneous pop on the push cycle
        send(7'h7F); send(7'h00); send(7'h55); send(7'h7F);
        code_in    = 7'h00;
        code_valid = 1'b1;
        @(negedge clk);
        code_valid = 1'b0;
        out_ready  = 1'b1;
        @(negedge clk);
        out_ready  = 1'b0;
        check("pushpop no overflow", 32'(overflow), 0);
        exp_q = '{4'h0, 4'hB, 4'hF, 4'h0};
        foreach (exp_q[i]) begin
            check($sformatf("pp%0d valid", i), 32'(out_valid), 1);
            check($sformatf("pp%0d data", i), 32'(data_out), 32'(exp_q[i]));
            pop_one();
        end
        check("pp empty", 32'(out_valid), 0);

        // ena low between capture and push
        code_in    = 7'h55;
        code_valid = 1'b1;
        @(negedge clk);
        ena        = 1'b0;
        code_valid = 1'b0;
        repeat (3) @(negedge clk);
        check("ena hold empty", 32'(out_valid), 0);
        ena = 1'b1;
        @(negedge clk);
        check("ena resume valid", 32'(out_valid), 1);
        check("ena resume data", 32'(data_out), 32'hB);
        pop_one();

        // stats_clr wins over a same-cycle increment
        code_in    = 7'h45;
        code_valid = 1'b1;
        @(negedge clk);
        code_valid = 1'b0;
        stats_clr  = 1'b1;
        @(negedge clk);
        stats_clr  = 1'b0;
        check("clr beats inc", 32'(corr_count), 0);
        check("clr push ok", 32'(out_valid), 1);
        pop_one();

        // Reset with two words queued
        send(7'h45); send(7'h7F);
        check("pre-reset count", 32'(corr_count), 1);
        rst_n = 1'b0;
        #1;
        check("reset async valid", 32'(out_valid), 0);
        check("reset async count", 32'(corr_count), 0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        check("post-reset empty", 32'(out_valid), 0);

        // Saturation of corr_count
        out_ready = 1'b1;
        exp_cc = 0;
        for (int i = 0; i < 260; i++) begin
            send(7'h45);
            if (exp_cc < 255) exp_cc++;
        end
        out_ready = 1'b0;
        @(negedge clk);
        check("saturate count", 32'(corr_count), 32'(exp_cc));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
